nn_mul_pipe_mac: RTL and testbench

//  Parametrised pipelined signed multiplier, successor to the single-cycle NN_mul_* cores.

---
 rtl/nn_mul_pipe_mac_pkg.sv | 28 ++
 rtl/nn_mul_pipe_mac_if.sv | 25 ++
 rtl/nn_mul_pipe_mac_round_sat.sv | 42 ++++
 rtl/nn_mul_pipe_mac.sv | 116 +++++++++++
 tb/tb_nn_mul_pipe_mac.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/nn_mul_pipe_mac_pkg.sv
// Shared width derivations, saturation constants and parameter-legality check
// for the pipelined multiplier / MAC.
package nn_mul_pkg;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic int acc_w(input int a_w, input int b_w, input int guard);
    return a_w + b_w + guard;
  endfunction

  // Largest positive value of a w-bit signed number; callers truncate to w bits.
  // The most negative value is its bitwise complement.
  function automatic logic [255:0] sat_max(input int w);
    logic [255:0] one;
    one = 256'(1);
    return (one << (w - 1)) - one;
  endfunction

endpackage

`ifndef NN_MUL_CHECK_PARAMS
`define NN_MUL_CHECK_PARAMS(ns, sh, aw) \
  if ((ns) < 1 || (sh) >= (aw)) begin : g_param_err \
    $error("nn_mul_pipe_mac: NUM_STAGE must be >= 1 and SHIFT < ACC_W"); \
  end
`endif

// File: rtl/nn_mul_pipe_mac_if.sv
// Sample/result bundle between a datapath producer and the multiplier/MAC.
interface nn_mul_pipe_mac_if #(
  parameter int din0_WIDTH = 43,
  parameter int din1_WIDTH = 25,
  parameter int dout_WIDTH = 67
);
  logic                          in_valid;
  logic                          acc_en;
  logic                          acc_clr;
  logic signed [din0_WIDTH-1:0]  din0;
  logic signed [din1_WIDTH-1:0]  din1;
  logic                          out_valid;
  logic signed [dout_WIDTH-1:0]  dout;
  logic                          ovf;

  modport master (
    output in_valid, acc_en, acc_clr, din0, din1,
    input  out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, acc_en, acc_clr, din0, din1,
    output out_valid, dout, ovf
  );
endinterface

// File: rtl/nn_mul_pipe_mac_round_sat.sv
// Combinational rescale of the accumulator: round half toward +inf after an
// arithmetic right shift, then saturate to the output width.
module nn_round_sat
  import nn_mul_pkg::*;
#(
  parameter int ACC_W      = 72,
  parameter int dout_WIDTH = 67,
  parameter int SHIFT      = 0
) (
  input  logic signed [ACC_W-1:0]      acc,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);
  localparam int RW = (SHIFT == 0) ? ACC_W : ACC_W + 1 - SHIFT;

  logic signed [RW-1:0] r;

  if (SHIFT == 0) begin : g_noshift
    assign r = acc;
  end else begin : g_round
    // One extra bit so adding the rounding half never wraps.
    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
    logic signed [ACC_W:0] sum;
    assign sum = {acc[ACC_W-1], acc} + HALF;
    assign r   = RW'(sum >>> SHIFT);
  end

  if (dout_WIDTH >= ACC_W - SHIFT) begin : g_wide
    assign dout = dout_WIDTH'(r);
    assign ovf  = 1'b0;
  end else begin : g_sat
    localparam logic [dout_WIDTH-1:0] SAT_MAX = dout_WIDTH'(sat_max(dout_WIDTH));
    localparam logic [dout_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    logic [RW-dout_WIDTH:0] top;
    assign top = r[RW-1:dout_WIDTH-1];
    always_comb begin
      ovf  = !((&top) || !(|top));
      dout = r[dout_WIDTH-1:0];
      if (ovf) dout = r[RW-1] ? SAT_MIN : SAT_MAX;
    end
  end
endmodule

// File: rtl/nn_mul_pipe_mac.sv
// Pipelined signed multiplier with optional accumulate, clock-enable stall and
// round/saturate of the result.
module nn_mul_pipe_mac
  import nn_mul_pkg::*;
#(
  parameter int din0_WIDTH = 43,
  parameter int din1_WIDTH = 25,
  parameter int dout_WIDTH = 67,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0,
  parameter int GUARD_BITS = 4
) (
  input logic               ap_clk,
  input logic               ap_rst_n,
  input logic               ce,
  nn_mul_pipe_mac_if.slave  bus
);
  localparam int PW = prod_w(din0_WIDTH, din1_WIDTH);
  localparam int AW = acc_w(din0_WIDTH, din1_WIDTH, GUARD_BITS);
  localparam int SW = AW + 3;

  `NN_MUL_CHECK_PARAMS(NUM_STAGE, SHIFT, AW)

  // Word layout along the pipe: {valid, acc_en, acc_clr, product}.
  logic [SW-1:0] f_word;

  if (NUM_STAGE == 1) begin : g_comb
    logic signed [PW-1:0] p;
    assign p      = PW'(bus.din0) * PW'(bus.din1);
    assign f_word = {bus.in_valid, bus.acc_en, bus.acc_clr, AW'(p)};
  end else begin : g_pipe
    logic                         v_q, en_q, clr_q;
    logic signed [din0_WIDTH-1:0] a_q;
    logic signed [din1_WIDTH-1:0] b_q;
    logic signed [PW-1:0]         p;
    logic [SW-1:0]                s1_word;

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        v_q   <= 1'b0;
        en_q  <= 1'b0;
        clr_q <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
      end else if (ce) begin
        v_q   <= bus.in_valid;
        en_q  <= bus.acc_en;
        clr_q <= bus.acc_clr;
        a_q   <= bus.din0;
        b_q   <= bus.din1;
      end
    end

    assign p       = PW'(a_q) * PW'(b_q);
    assign s1_word = {v_q, en_q, clr_q, AW'(p)};

    for (genvar i = 0; i < NUM_STAGE - 2; i++) begin : g_dly
      logic [SW-1:0] d;
      logic [SW-1:0] q;
      if (i == 0) begin : g_first
        assign d = s1_word;
      end else begin : g_next
        assign d = g_dly[i-1].q;
      end
      always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)  q <= '0;
        else if (ce)    q <= d;
      end
    end

    if (NUM_STAGE == 2) begin : g_tap1
      assign f_word = s1_word;
    end else begin : g_tapn
      assign f_word = g_dly[NUM_STAGE-3].q;
    end
  end

  logic                         f_valid, f_en, f_clr;
  logic signed [AW-1:0]         f_p;
  logic signed [AW-1:0]         acc, acc_n;
  logic signed [dout_WIDTH-1:0] rs_dout;
  logic                         rs_ovf;

  assign {f_valid, f_en, f_clr, f_p} = f_word;

  always_comb begin
    acc_n = f_p;
    if (f_en && !f_clr) acc_n = acc + f_p;
  end

  nn_round_sat #(
    .ACC_W      (AW),
    .dout_WIDTH (dout_WIDTH),
    .SHIFT      (SHIFT)
  ) u_round_sat (
    .acc  (acc_n),
    .dout (rs_dout),
    .ovf  (rs_ovf)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc           <= '0;
      bus.dout      <= '0;
      bus.ovf       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (ce) begin
      bus.out_valid <= f_valid;
      if (f_valid) begin
        acc      <= acc_n;
        bus.dout <= rs_dout;
        bus.ovf  <= rs_ovf;
      end
    end
  end
endmodule

// File: tb/tb_nn_mul_pipe_mac.sv
// Scoreboard bench for nn_mul_pipe_mac in the 8x8 -> 8, SHIFT=4, 3-stage config.
module tb_nn_mul_pipe_mac;
  logic clk = 1'b0;
  logic rst_n;
  logic ce;

  always #5 clk = ~clk;

  nn_mul_pipe_mac_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8)) bus ();

  nn_mul_pipe_mac #(
    .din0_WIDTH (8),
    .din1_WIDTH (8),
    .dout_WIDTH (8),
    .NUM_STAGE  (3),
    .SHIFT      (4),
    .GUARD_BITS (4)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .ce       (ce),
    .bus      (bus)
  );

  typedef struct packed {
    logic signed [7:0] d;
    logic              o;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input int a, input int b, input logic en,
                     input logic clr, input logic c, input int ed, input logic eo);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.din0     = 8'(a);
    bus.din1     = 8'(b);
    bus.acc_en   = en;
    bus.acc_clr  = clr;
    ce           = c;
    if (v && c) begin
      e.d = 8'(ed);
      e.o = eo;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
  endtask

  // Monitor: bench-side valid pipeline decides when a result is due.
  logic [2:0]        vp = '0;
  logic signed [7:0] last_d = '0;
  logic              last_o = 1'b0;
  logic              ce_e, rst_e, v_e;
  exp_t              got;

  initial begin
    forever begin
      @(posedge clk);
      ce_e  = ce;
      rst_e = rst_n;
      v_e   = bus.in_valid;
      #1;
      if (!rst_e) begin
        vp     = '0;
        last_d = '0;
        last_o = 1'b0;
        sb.delete();
      end else if (ce_e) begin
        vp = {vp[1:0], v_e};
      end
      check("out_valid", int'(bus.out_valid), int'(vp[2]));
      if (rst_e && ce_e && vp[2]) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got result %0d with no expectation", bus.dout);
        end else begin
          got = sb.pop_front();
          check("dout", int'(bus.dout), int'(got.d));
          check("ovf", int'(bus.ovf), int'(got.o));
          last_d = got.d;
          last_o = got.o;
        end
      end else begin
        check("dout_hold", int'(bus.dout), int'(last_d));
        check("ovf_hold", int'(bus.ovf), int'(last_o));
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.din0     = '0;
    bus.din1     = '0;
    bus.acc_en   = 1'b0;
    bus.acc_clr  = 1'b0;
    ce           = 1'b1;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Plain multiply, rounding, saturation, acc_clr without acc_en
    cyc(1'b1,   16,  16, 1'b0, 1'b0, 1'b1,   16, 1'b0);
    cyc(1'b1,    3,   9, 1'b0, 1'b0, 1'b1,    2, 1'b0);
    cyc(1'b1,   -3,   9, 1'b0, 1'b0, 1'b1,   -2, 1'b0);
    cyc(1'b1,  127, 127, 1'b0, 1'b0, 1'b1,  127, 1'b1);
    cyc(1'b1, -128, 127, 1'b0, 1'b0, 1'b1, -128, 1'b1);
    cyc(1'b1,    5,  16, 1'b0, 1'b1, 1'b1,    5, 1'b0);
    idle(4);

    // MAC with a bubble and a restart
    cyc(1'b1, 16, 16, 1'b1, 1'b1, 1'b1, 16, 1'b0);
    cyc(1'b1, 16, 16, 1'b1, 1'b0, 1'b1, 32, 1'b0);
    idle(1);
    cyc(1'b1, 16, 16, 1'b1, 1'b0, 1'b1, 48, 1'b0);
    cyc(1'b1, 16, 16, 1'b1, 1'b1, 1'b1, 16, 1'b0);
    idle(4);

    // Stalls on the input side and while results are emerging
    cyc(1'b1,   3,   9, 1'b0, 1'b0, 1'b1,  2, 1'b0);
    cyc(1'b1,  16,  16, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    cyc(1'b1, 127, 127, 1'b0, 1'b0, 1'b0,  0, 1'b0);
    cyc(1'b1, 127, 127, 1'b0, 1'b0, 1'b0,  0, 1'b0);
    cyc(1'b1,  -3,   9, 1'b0, 1'b0, 1'b1, -2, 1'b0);
    idle(1);
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);

    // Reset with two samples in flight; acc holds -27 beforehand
    cyc(1'b1, 16, 16, 1'b1, 1'b1, 1'b1, 16, 1'b0);
    cyc(1'b1, 16, 16, 1'b1, 1'b0, 1'b1, 32, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    cyc(1'b1, 16, 16, 1'b1, 1'b0, 1'b1, 16, 1'b0);
    idle(5);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
